// File: rtl/alu_seq_responder.sv
// Handshaked ALU responder: single-cycle logic ops, serial one-bit-per-cycle shifts,
// and a 32-iteration shift-add multiplier, with a registered result held until consumed.
module alu_seq_responder #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       shamt,
    input  logic [3:0]       ALUctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] val_q, val_d;     // shift operand, or MUL multiplicand
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       sop_q, sop_d;     // 0 SLL, 1 SRL, 2 SRA (low bits of ALUctrl 8..10)
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        alu_res = '0;
        case (ALUctrl)
            4'd0:    alu_res = in1 + in2;
            4'd1:    alu_res = in1 - in2;
            4'd2:    alu_res = in1 & in2;
            4'd3:    alu_res = in1 | in2;
            4'd4:    alu_res = in1 ^ in2;
            4'd5:    alu_res = ~(in1 | in2);
            4'd6:    alu_res[0] = $signed(in1) < $signed(in2);
            4'd7:    alu_res[0] = in1 < in2;
            4'd11:   alu_res = in2 << 16;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (sop_q)
            2'd0:    shifted = val_q << 1;
            2'd1:    shifted = val_q >> 1;
            default: shifted = {val_q[WIDTH-1], val_q[WIDTH-1:1]};
        endcase
        acc_next = mplr_q[0] ? (acc_q + val_q) : acc_q;
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        val_d   = val_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    case (ALUctrl)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11: begin
                            out_d  = alu_res;
                            zero_d = (alu_res == '0);
                        end
                        4'd8, 4'd9, 4'd10: begin
                            if (shamt == 5'd0) begin
                                out_d  = in2;
                                zero_d = (in2 == '0);
                            end else begin
                                val_d   = in2;
                                cnt_d   = {1'b0, shamt};
                                sop_d   = ALUctrl[1:0];
                                state_d = S_SHIFT;
                            end
                        end
                        4'd12: begin
                            if (MUL_EN) begin
                                val_d   = in1;
                                mplr_d  = in2;
                                acc_d   = '0;
                                cnt_d   = 6'd32;
                                state_d = S_MUL;
                            end else begin
                                out_d  = '0;
                                zero_d = 1'b1;
                                err_d  = 1'b1;
                            end
                        end
                        default: begin
                            out_d  = '0;
                            zero_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                val_d = shifted;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    out_d   = shifted;
                    zero_d  = (shifted == '0);
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                acc_d  = acc_next;
                val_d  = val_q << 1;
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    out_d   = acc_next;
                    zero_d  = (acc_next == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            val_q   <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sop_q   <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            val_q   <= val_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_responder.sv
// Self-checking bench for alu_seq_responder: directed vector table, random requests
// against a behavioural model, plus backpressure and mid-operation reset sequences.
module tb_alu_seq_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] in1, in2;
    logic [4:0]  shamt;
    logic [3:0]  ALUctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] out;
    logic        zero;
    logic        err;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    alu_seq_responder #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .in1(in1), .in2(in2), .shamt(shamt), .ALUctrl(ALUctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .out(out), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_err;
        int unsigned exp_lat;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the opcode table, using full-width arithmetic.
    function automatic logic [31:0] model_out(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return b << sh;
            4'd9:    return b >> sh;
            4'd10:   return $unsigned($signed(b) >>> sh);
            4'd11:   return b << 16;
            4'd12:   return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [3:0] c, input logic [4:0] sh);
        if (c >= 4'd8 && c <= 4'd10) return (sh == 5'd0) ? 1 : int'(sh) + 1;
        if (c == 4'd12) return 33;
        return 1;
    endfunction

    task automatic run_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input int unsigned dly,
                           output logic [31:0] o, output logic z, output logic e,
                           output int unsigned lat);
        int unsigned w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        ALUctrl = c; in1 = a; in2 = b; shamt = sh; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; shamt = 5'($urandom); ALUctrl = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1; lat++;
        end
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        o = out; z = zero; e = err;
        for (int i = 0; i < int'(dly); i++) begin
            @(posedge clk); #1;
            chk("hold_out", out, o);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] o;
        logic        z, e;
        int unsigned lat, w;
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        logic [4:0]  rs;

        //            ctrl   a             b             sh     out           z     e     lat
        vecs[0]  = '{4'd0,  32'd20,       32'd10,       5'd0,  32'd30,       1'b0, 1'b0, 1};
        vecs[1]  = '{4'd1,  32'd20,       32'd10,       5'd0,  32'd10,       1'b0, 1'b0, 1};
        vecs[2]  = '{4'd2,  32'd20,       32'd10,       5'd0,  32'd0,        1'b1, 1'b0, 1};
        vecs[3]  = '{4'd3,  32'd20,       32'd10,       5'd0,  32'd30,       1'b0, 1'b0, 1};
        vecs[4]  = '{4'd4,  32'd20,       32'd10,       5'd0,  32'd30,       1'b0, 1'b0, 1};
        vecs[5]  = '{4'd8,  32'd0,        32'd10,       5'd2,  32'd40,       1'b0, 1'b0, 3};
        vecs[6]  = '{4'd9,  32'd0,        32'd10,       5'd2,  32'd2,        1'b0, 1'b0, 3};
        vecs[7]  = '{4'd10, 32'd0,        32'hFFFFFFF8, 5'd2,  32'hFFFFFFFE, 1'b0, 1'b0, 3};
        vecs[8]  = '{4'd12, 32'd20,       32'd10,       5'd0,  32'd200,      1'b0, 1'b0, 33};
        vecs[9]  = '{4'd12, 32'hFFFFFFFF, 32'd2,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 33};
        vecs[10] = '{4'd6,  32'd20,       32'd10,       5'd0,  32'd0,        1'b1, 1'b0, 1};
        vecs[11] = '{4'd6,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1'b0, 1};
        vecs[12] = '{4'd7,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1, 1'b0, 1};
        vecs[13] = '{4'd13, 32'd20,       32'd10,       5'd0,  32'd0,        1'b1, 1'b1, 1};
        vecs[14] = '{4'd8,  32'd7,        32'h00001234, 5'd0,  32'h00001234, 1'b0, 1'b0, 1};
        vecs[15] = '{4'd10, 32'd0,        32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
        vecs[16] = '{4'd11, 32'd0,        32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0, 1'b0, 1};
        vecs[17] = '{4'd5,  32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vecs[18] = '{4'd15, 32'd1,        32'd1,        5'd3,  32'd0,        1'b1, 1'b1, 1};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        in1 = '0; in2 = '0; shamt = '0; ALUctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_out", out, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_req(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, i % 3, o, z, e, lat);
            chk("vec_out", o, vecs[i].exp_out);
            chk("vec_zero", {31'd0, z}, {31'd0, vecs[i].exp_zero});
            chk("vec_err", {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk("vec_lat", lat, vecs[i].exp_lat);
        end

        for (int i = 0; i < 60; i++) begin
            rc = 4'($urandom_range(15));
            ra = (i % 4 == 0) ? 32'($urandom_range(3)) : $urandom;
            rb = (i % 5 == 0) ? 32'($urandom_range(3)) : $urandom;
            rs = 5'($urandom);
            run_req(rc, ra, rb, rs, $urandom_range(2), o, z, e, lat);
            chk("rand_out", o, model_out(rc, ra, rb, rs));
            chk("rand_zero", {31'd0, z}, (model_out(rc, ra, rb, rs) == 32'd0) ? 32'd1 : 32'd0);
            chk("rand_err", {31'd0, e}, (rc >= 4'd13) ? 32'd1 : 32'd0);
            chk("rand_lat", lat, model_lat(rc, rs));
        end

        // Backpressure: result held for 10 cycles while a competing request is offered.
        ALUctrl = 4'd0; in1 = 32'd20; in2 = 32'd10; req_valid = 1'b1;
        @(posedge clk); #1;
        ALUctrl = 4'd1; in1 = 32'd99; in2 = 32'd1;
        w = 0;
        while (!rsp_valid && w < 64) begin
            @(posedge clk); #1; w++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out", out, 32'd30);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

        // Reset lands on MUL clock 10; the pending product must vanish.
        ALUctrl = 4'd12; in1 = 32'd20; in2 = 32'd10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_out", out, 32'd0);
        run_req(4'd0, 32'd20, 32'd10, 5'd0, 0, o, z, e, lat);
        chk("post_rst_add", o, 32'd30);
        chk("post_rst_lat", lat, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
